// File: rtl/bp_me_cache_dma_mem_if.sv
// Command/response/SRAM signal bundle between the L2 slice DMA side, the
// backing-memory endpoint and its SRAM macro.
interface bp_me_cache_dma_mem_if #(
  parameter int hdr_w       = 57,
  parameter int dword_w     = 64,
  parameter int sram_addr_w = 16
);
  logic [hdr_w-1:0]       mem_cmd_header_i;
  logic                   mem_cmd_header_v_i;
  logic                   mem_cmd_header_yumi_o;
  logic [dword_w-1:0]     mem_cmd_data_i;
  logic                   mem_cmd_data_v_i;
  logic                   mem_cmd_data_yumi_o;
  logic [hdr_w-1:0]       mem_resp_header_o;
  logic                   mem_resp_header_v_o;
  logic                   mem_resp_header_ready_i;
  logic [dword_w-1:0]     mem_resp_data_o;
  logic                   mem_resp_data_v_o;
  logic                   mem_resp_data_ready_i;
  logic                   sram_v_o;
  logic                   sram_w_o;
  logic [sram_addr_w-1:0] sram_addr_o;
  logic [dword_w-1:0]     sram_data_o;
  logic [dword_w-1:0]     sram_data_i;

  modport slave (
    input  mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
           mem_resp_header_ready_i, mem_resp_data_ready_i, sram_data_i,
    output mem_cmd_header_yumi_o, mem_cmd_data_yumi_o, mem_resp_header_o,
           mem_resp_header_v_o, mem_resp_data_o, mem_resp_data_v_o,
           sram_v_o, sram_w_o, sram_addr_o, sram_data_o
  );

  modport master (
    output mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
           mem_resp_header_ready_i, mem_resp_data_ready_i, sram_data_i,
    input  mem_cmd_header_yumi_o, mem_cmd_data_yumi_o, mem_resp_header_o,
           mem_resp_header_v_o, mem_resp_data_o, mem_resp_data_v_o,
           sram_v_o, sram_w_o, sram_addr_o, sram_data_o
  );
endinterface

// File: rtl/bp_me_cache_dma_mem.sv
// Backing-memory endpoint behind the L2 slice DMA port: whole-block reads and
// writes against a single-port synchronous SRAM, one dword beat per cycle.
module bp_me_cache_dma_mem #(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512,
  parameter int lce_id_width_p    = 4,
  parameter int lce_assoc_p       = 8,
  parameter int mem_els_p         = 2**16
) (
  input logic clk_i,
  input logic reset_i,
  bp_me_cache_dma_mem_if.slave mem
);
  localparam int beats_lp     = cce_block_width_p / dword_width_p;
  localparam int lg_beats_lp  = $clog2(beats_lp);
  localparam int lg_mem_lp    = $clog2(mem_els_p);
  localparam int payload_w_lp = lce_id_width_p + $clog2(lce_assoc_p) + 3;
  // Header layout, LSB first: msg_type[3:0], size[2:0], addr, payload.
  localparam int addr_lsb_lp  = 7;
  localparam int cce_mem_msg_header_width_lp = addr_lsb_lp + paddr_width_p + payload_w_lp;
  localparam logic [cce_mem_msg_header_width_lp-1:0] keep_mask_lp =
    {{payload_w_lp{1'b0}}, {(cce_mem_msg_header_width_lp-payload_w_lp){1'b1}}};

  typedef enum logic [2:0] {e_ready, e_write, e_wr_resp, e_rd_hdr, e_rd_data} state_e;

  state_e                             state_r, state_n;
  logic [cce_mem_msg_header_width_lp-1:0] hdr_r;
  logic [lg_beats_lp:0]               cnt_r;
  logic [dword_width_p-1:0]           fifo_r [2];
  logic                               wptr_r, rptr_r, inflight_r;
  logic [1:0]                         fcnt_r, occ;
  logic                               wr_cmd, deq, issue, hdr_acc, wr_beat, rd_done;

  assign wr_cmd  = (mem.mem_cmd_header_i[3:0] == 4'b0001) || (mem.mem_cmd_header_i[3:0] == 4'b0011);
  assign deq     = (fcnt_r != 2'd0) & mem.mem_resp_data_ready_i & ~reset_i;
  // Slots still owed: queued beats plus the read whose data lands next cycle.
  assign occ     = fcnt_r + 2'(inflight_r) - 2'(deq);
  assign issue   = ~reset_i & (state_r == e_rd_data) & ~cnt_r[lg_beats_lp] & (occ < 2'd2);
  assign hdr_acc = ~reset_i & (state_r == e_ready) & mem.mem_cmd_header_v_i;
  assign wr_beat = ~reset_i & (state_r == e_write) & mem.mem_cmd_data_v_i;
  assign rd_done = cnt_r[lg_beats_lp] & ~inflight_r & (fcnt_r == 2'd1) & deq;

  assign mem.sram_addr_o       = {hdr_r[addr_lsb_lp+lg_mem_lp+2 : addr_lsb_lp+3+lg_beats_lp],
                                  cnt_r[lg_beats_lp-1:0]};
  assign mem.sram_data_o       = mem.mem_cmd_data_i;
  assign mem.mem_resp_header_o = hdr_r & keep_mask_lp;
  assign mem.mem_resp_data_o   = fifo_r[rptr_r];
  assign mem.mem_resp_data_v_o = (fcnt_r != 2'd0) & ~reset_i;

  always_comb begin
    state_n                   = state_r;
    mem.mem_cmd_header_yumi_o = 1'b0;
    mem.mem_cmd_data_yumi_o   = 1'b0;
    mem.mem_resp_header_v_o   = 1'b0;
    mem.sram_v_o              = 1'b0;
    mem.sram_w_o              = 1'b0;
    case (state_r)
      e_ready: begin
        mem.mem_cmd_header_yumi_o = mem.mem_cmd_header_v_i;
        if (mem.mem_cmd_header_v_i) state_n = wr_cmd ? e_write : e_rd_hdr;
      end
      e_write: begin
        mem.mem_cmd_data_yumi_o = mem.mem_cmd_data_v_i;
        mem.sram_v_o            = mem.mem_cmd_data_v_i;
        mem.sram_w_o            = mem.mem_cmd_data_v_i;
        if (mem.mem_cmd_data_v_i && cnt_r[lg_beats_lp-1:0] == lg_beats_lp'(beats_lp-1))
          state_n = e_wr_resp;
      end
      e_wr_resp: begin
        mem.mem_resp_header_v_o = 1'b1;
        if (mem.mem_resp_header_ready_i) state_n = e_ready;
      end
      e_rd_hdr: begin
        mem.mem_resp_header_v_o = 1'b1;
        if (mem.mem_resp_header_ready_i) state_n = e_rd_data;
      end
      e_rd_data: begin
        mem.sram_v_o = issue;
        if (rd_done) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
    if (reset_i) begin
      mem.mem_cmd_header_yumi_o = 1'b0;
      mem.mem_cmd_data_yumi_o   = 1'b0;
      mem.mem_resp_header_v_o   = 1'b0;
      mem.sram_v_o              = 1'b0;
      mem.sram_w_o              = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      cnt_r      <= '0;
      fcnt_r     <= '0;
      wptr_r     <= 1'b0;
      rptr_r     <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      inflight_r <= issue;
      if (hdr_acc) cnt_r <= '0;
      else if (wr_beat || issue) cnt_r <= cnt_r + 1'b1;
      if (inflight_r) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      fcnt_r <= fcnt_r + 2'(inflight_r) - 2'(deq);
    end
  end

  // Datapath storage needs no reset; the control above qualifies it.
  always_ff @(posedge clk_i) begin
    if (hdr_acc) hdr_r <= mem.mem_cmd_header_i;
    if (!reset_i && inflight_r) fifo_r[wptr_r] <= mem.sram_data_i;
  end
endmodule
